// File: rtl/sdram_read_pkg.sv
// Shared constants for the SDRAM read path: command encodings, timing defaults,
// read-engine state encoding and address helpers.
package sdram_para;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_PRE  = 4'b0010;

    localparam int CL_DEF   = 3;
    localparam int TRCD_DEF = 2;
    localparam int TRP_DEF  = 2;
    localparam int BURST    = 4;

    // Column of the last burst in a row; the next READ would wrap to 0.
    localparam logic [8:0]  COL_MAX      = 9'd508;
    localparam logic [11:0] ADDR_PRE_ALL = 12'h400;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ASK      = 3'd1;
    localparam logic [2:0] ST_ACT      = 3'd2;
    localparam logic [2:0] ST_WAIT_RCD = 3'd3;
    localparam logic [2:0] ST_READ     = 3'd4;
    localparam logic [2:0] ST_PRE      = 3'd5;
    localparam logic [2:0] ST_WAIT_RP  = 3'd6;

    // Why the engine left the READ state; decides what follows the precharge.
    typedef enum logic [1:0] {
        EXIT_DONE,
        EXIT_ROW,
        EXIT_PREEMPT
    } rd_exit_e;

    // READ address: column on [8:0], A10 low so the bank stays open.
    function automatic logic [11:0] read_addr(input logic [8:0] col);
        return {3'b000, col};
    endfunction

endpackage

// File: rtl/sdram_rd_capture.sv
// DQ capture register plus a CL+1 deep valid shift register fed by the
// per-cycle READ slot strobe.
module sdram_rd_capture #(
    parameter int CL = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rd_slot_i,
    input  logic [15:0] dq_i,
    output logic [15:0] data_o,
    output logic        valid_o,
    output logic        busy_o
);

    logic [CL:0]  vld_q;
    logic [15:0]  data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= {vld_q[CL-1:0], rd_slot_i};
            data_q <= dq_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = vld_q[CL];
    // Low in the last valid cycle: nothing further is still on its way out.
    assign busy_o  = rd_slot_i | (|vld_q[CL-1:0]);

endmodule

// File: rtl/sdram_read.sv
// SDRAM read engine: arbitrates for the bus, opens a row, streams burst-of-4
// READs, precharges, and yields at burst boundaries or row ends.
module sdram_read
    import sdram_para::*;
#(
    parameter int CL   = CL_DEF,
    parameter int TRCD = TRCD_DEF,  // must be >= 2
    parameter int TRP  = TRP_DEF    // must be >= 2
) (
    input  logic        sclk,
    input  logic        srst,
    input  logic        rd_en,
    output logic        flag_rd_ask,
    output logic        flag_rd_end,
    input  logic        rd_trig,
    input  logic [11:0] rd_row,
    input  logic [7:0]  rd_len,
    input  logic [15:0] sdram_dq,
    output logic [15:0] rd_data,
    output logic        rd_data_valid,
    output logic [3:0]  sdram_cmd,
    output logic [11:0] sdram_addr
);

    logic [2:0]  st_q,   st_d;
    logic [11:0] row_q,  row_d;
    logic [8:0]  col_q,  col_d;
    logic [7:0]  rem_q,  rem_d;
    logic [1:0]  beat_q, beat_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        last_q, last_d;
    rd_exit_e    exit_q, exit_d;
    logic [3:0]  cmd_q,  cmd_d;
    logic [11:0] addr_q, addr_d;
    logic        end_q,  end_d;
    logic        slot_q, slot_d;
    logic        cap_busy;

    always_comb begin
        st_d   = st_q;
        row_d  = row_q;
        col_d  = col_q;
        rem_d  = rem_q;
        beat_d = beat_q;
        wcnt_d = wcnt_q;
        last_d = last_q;
        exit_d = exit_q;
        cmd_d  = CMD_NOP;
        addr_d = 12'd0;
        end_d  = 1'b0;
        slot_d = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (rd_trig && rd_len != 8'd0) begin
                    row_d  = rd_row;
                    rem_d  = rd_len;
                    col_d  = 9'd0;
                    last_d = 1'b0;
                    st_d   = ST_ASK;
                end
            end
            ST_ASK: begin
                if (rd_en) st_d = ST_ACT;
            end
            ST_ACT: begin
                cmd_d  = CMD_ACT;
                addr_d = row_q;
                beat_d = 2'd0;
                wcnt_d = 4'(TRCD - 2);
                st_d   = ST_WAIT_RCD;
            end
            ST_WAIT_RCD: begin
                if (wcnt_q == 4'd0) st_d = ST_READ;
                else                wcnt_d = wcnt_q - 4'd1;
            end
            ST_READ: begin
                slot_d = 1'b1;
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd0) begin
                    cmd_d  = CMD_READ;
                    addr_d = read_addr(col_q);
                    col_d  = col_q + 9'(BURST);
                    rem_d  = rem_q - 8'd1;
                    last_d = (col_q == COL_MAX);
                end
                // Exit decisions only at the end of a burst slot so no burst is cut short.
                if (beat_q == 2'(BURST - 1)) begin
                    if (rem_q == 8'd0) begin
                        exit_d = EXIT_DONE;
                        st_d   = ST_PRE;
                    end else if (last_q) begin
                        exit_d = EXIT_ROW;
                        row_d  = row_q + 12'd1;
                        st_d   = ST_PRE;
                    end else if (!rd_en) begin
                        exit_d = EXIT_PREEMPT;
                        st_d   = ST_PRE;
                    end
                end
            end
            ST_PRE: begin
                cmd_d  = CMD_PRE;
                addr_d = ADDR_PRE_ALL;
                wcnt_d = 4'(TRP - 2);
                st_d   = ST_WAIT_RP;
            end
            ST_WAIT_RP: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    // Releasing the bus waits until the last captured word has gone out.
                    case (exit_q)
                        EXIT_ROW: begin
                            if (rd_en) begin
                                st_d = ST_ACT;
                            end else if (!cap_busy) begin
                                end_d = 1'b1;
                                st_d  = ST_ASK;
                            end
                        end
                        EXIT_PREEMPT: begin
                            if (!cap_busy) begin
                                end_d = 1'b1;
                                st_d  = ST_ASK;
                            end
                        end
                        default: begin
                            if (!cap_busy) begin
                                end_d = 1'b1;
                                st_d  = ST_IDLE;
                            end
                        end
                    endcase
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            st_q   <= ST_IDLE;
            row_q  <= 12'd0;
            col_q  <= 9'd0;
            rem_q  <= 8'd0;
            beat_q <= 2'd0;
            wcnt_q <= 4'd0;
            last_q <= 1'b0;
            exit_q <= EXIT_DONE;
            cmd_q  <= CMD_NOP;
            addr_q <= 12'd0;
            end_q  <= 1'b0;
            slot_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            row_q  <= row_d;
            col_q  <= col_d;
            rem_q  <= rem_d;
            beat_q <= beat_d;
            wcnt_q <= wcnt_d;
            last_q <= last_d;
            exit_q <= exit_d;
            cmd_q  <= cmd_d;
            addr_q <= addr_d;
            end_q  <= end_d;
            slot_q <= slot_d;
        end
    end

    sdram_rd_capture #(.CL(CL)) u_cap (
        .clk_i     (sclk),
        .rst_i     (srst),
        .rd_slot_i (slot_q),
        .dq_i      (sdram_dq),
        .data_o    (rd_data),
        .valid_o   (rd_data_valid),
        .busy_o    (cap_busy)
    );

    assign flag_rd_ask = (st_q == ST_ASK);
    assign flag_rd_end = end_q;
    assign sdram_cmd   = cmd_q;
    assign sdram_addr  = addr_q;

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read: CL=3 main instance with an SDRAM data model,
// plus a CL=2 instance sharing the stimulus for latency checks.
module tb_sdram_read;

    localparam int CL   = 3;
    localparam int TRCD = 2;
    localparam int TRP  = 2;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] PRE = 4'b0010;

    logic        sclk = 1'b0;
    logic        srst = 1'b1;
    logic        rd_en = 1'b0;
    logic        rd_trig = 1'b0;
    logic [11:0] rd_row = 12'd0;
    logic [7:0]  rd_len = 8'd0;
    logic [15:0] sdram_dq = 16'd0;

    logic        ask, endp, rvalid, ask2, end2, rvalid2;
    logic [15:0] rdata, rdata2;
    logic [3:0]  cmd, cmd2;
    logic [11:0] addr, addr2;

    always #5 sclk = ~sclk;

    sdram_read #(.CL(CL), .TRCD(TRCD), .TRP(TRP)) dut (
        .sclk(sclk), .srst(srst), .rd_en(rd_en), .flag_rd_ask(ask), .flag_rd_end(endp),
        .rd_trig(rd_trig), .rd_row(rd_row), .rd_len(rd_len), .sdram_dq(sdram_dq),
        .rd_data(rdata), .rd_data_valid(rvalid), .sdram_cmd(cmd), .sdram_addr(addr)
    );

    sdram_read #(.CL(2), .TRCD(TRCD), .TRP(TRP)) dut2 (
        .sclk(sclk), .srst(srst), .rd_en(rd_en), .flag_rd_ask(ask2), .flag_rd_end(end2),
        .rd_trig(rd_trig), .rd_row(rd_row), .rd_len(rd_len), .sdram_dq(sdram_dq),
        .rd_data(rdata2), .rd_data_valid(rvalid2), .sdram_cmd(cmd2), .sdram_addr(addr2)
    );

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int cur_row = 0;
    int trig_c = 0;
    int ask_rise = 0, bad_cmd = 0, cmd_n = 0, cmd2_n = 0, ask2_n = 0;
    logic ask_prev = 1'b0;
    int act_c[$], act_a[$], rd_c[$], rd_a[$], pre_c[$], pre_a[$];
    int v_c[$], v_d[$], end_c[$], r2_c[$], v2_c[$];
    logic [15:0] dq_line [0:63];

    function automatic logic [15:0] word(input int row, input int col);
        return {7'(row), 9'(col)};
    endfunction

    function automatic int qat(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    // SDRAM data model: word for READ seen in cycle t is on DQ in cycles t+CL .. t+CL+3.
    initial begin
        for (int i = 0; i < 64; i++) dq_line[i] = 16'hDEAD;
        forever begin
            @(posedge sclk);
            cyc = cyc + 1;
            #1;
            sdram_dq = dq_line[cyc % 64];
            dq_line[cyc % 64] = 16'hDEAD;
        end
    end

    initial begin
        forever begin
            @(negedge sclk);
            if (cmd != NOP) cmd_n++;
            case (cmd)
                ACT: begin act_c.push_back(cyc); act_a.push_back(int'(addr)); cur_row = int'(addr); end
                RD: begin
                    rd_c.push_back(cyc);
                    rd_a.push_back(int'(addr));
                    for (int i = 0; i < 4; i++) dq_line[(cyc + CL + i) % 64] = word(cur_row, int'(addr[8:0]) + i);
                end
                PRE: begin pre_c.push_back(cyc); pre_a.push_back(int'(addr)); end
                NOP: ;
                default: bad_cmd++;
            endcase
            if (rvalid) begin v_c.push_back(cyc); v_d.push_back(int'(rdata)); end
            if (endp) end_c.push_back(cyc);
            if (rd_trig) trig_c = cyc;
            if (ask && !ask_prev) ask_rise++;
            ask_prev = ask;
            if (cmd2 == RD) r2_c.push_back(cyc);
            if (cmd2 != NOP) cmd2_n++;
            if (rvalid2) v2_c.push_back(cyc);
            if (ask2) ask2_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sclk);
        #2;
    endtask

    task automatic clear_logs();
        act_c.delete(); act_a.delete(); rd_c.delete(); rd_a.delete();
        pre_c.delete(); pre_a.delete(); v_c.delete(); v_d.delete();
        end_c.delete(); r2_c.delete(); v2_c.delete();
        ask_rise = 0; bad_cmd = 0; cmd_n = 0; cmd2_n = 0; ask2_n = 0;
    endtask

    task automatic trigger(input int row, input int len);
        @(posedge sclk); #1;
        rd_row = 12'(row); rd_len = 8'(len); rd_trig = 1'b1;
        @(posedge sclk); #1;
        rd_trig = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int n0, input int maxc);
        for (int i = 0; i < maxc && end_c.size() <= n0; i++) tick();
        chk(tag, end_c.size(), n0 + 1);
    endtask

    task automatic wait_reads(input int n, input int maxc);
        for (int i = 0; i < maxc && rd_c.size() < n; i++) tick();
    endtask

    // All captured words must follow address order from (row0, col 0).
    task automatic chk_stream(input string tag, input int row0);
        int bad;
        bad = 0;
        for (int k = 0; k < v_d.size(); k++)
            if (v_d[k] != int'(word(row0 + k / 512, k % 512))) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        repeat (3) @(posedge sclk);
        tick();
        chk("rst_cmd",   int'(cmd), int'(NOP));
        chk("rst_addr",  int'(addr), 0);
        chk("rst_ask",   int'(ask), 0);
        chk("rst_end",   int'(endp), 0);
        chk("rst_valid", int'(rvalid), 0);
        chk("rst_data",  int'(rdata), 0);
        @(posedge sclk); #1;
        srst = 1'b0;

        // Single burst, grant already present at trigger.
        clear_logs();
        rd_en = 1'b1;
        trigger(5, 1);
        wait_end("t1_end_seen", 0, 100);
        repeat (4) tick();
        chk("t1_act_n",    act_c.size(), 1);
        chk("t1_act_addr", qat(act_a, 0), 5);
        chk("t1_trig2act", qat(act_c, 0) - trig_c, 3);
        chk("t1_rd_n",     rd_c.size(), 1);
        chk("t1_rd_addr",  qat(rd_a, 0), 0);
        chk("t1_trcd",     qat(rd_c, 0) - qat(act_c, 0), TRCD);
        chk("t1_pre_n",    pre_c.size(), 1);
        chk("t1_pre_addr", qat(pre_a, 0), 12'h400);
        chk("t1_rd2pre",   qat(pre_c, 0) - qat(rd_c, 0), 4);
        chk("t1_v_n",      v_c.size(), 4);
        chk("t1_v_lat",    qat(v_c, 0) - qat(rd_c, 0), CL + 1);
        chk("t1_v_span",   qat(v_c, 3) - qat(v_c, 0), 3);
        chk_stream("t1_data", 5);
        chk("t1_end_n",    end_c.size(), 1);
        chk("t1_end_time", qat(end_c, 0) - qat(v_c, 3), 1);
        chk("t1_ask_rise", ask_rise, 1);
        chk("t1_bad_cmd",  bad_cmd, 0);
        chk("cl2_v_lat",   qat(v2_c, 0) - qat(r2_c, 0), 3);
        chk("cl2_v_n",     v2_c.size(), 4);

        // Three back-to-back bursts; a trigger mid-run must be ignored.
        clear_logs();
        trigger(162, 3);
        wait_reads(1, 50);
        trigger(99, 5);
        wait_end("t2_end_seen", 0, 100);
        repeat (4) tick();
        chk("t2_act_n",    act_c.size(), 1);
        chk("t2_act_addr", qat(act_a, 0), 162);
        chk("t2_rd_n",     rd_c.size(), 3);
        chk("t2_rd1",      qat(rd_a, 1), 4);
        chk("t2_rd2",      qat(rd_a, 2), 8);
        chk("t2_rd_span",  qat(rd_c, 2) - qat(rd_c, 0), 8);
        chk("t2_v_n",      v_c.size(), 12);
        chk("t2_v_gapless", qat(v_c, 11) - qat(v_c, 0), 11);
        chk_stream("t2_data", 162);
        chk("t2_rd2pre",   qat(pre_c, 0) - qat(rd_c, 2), 4);

        // Preemption during the first of two bursts, then re-grant.
        clear_logs();
        trigger(9, 2);
        wait_reads(1, 50);
        @(posedge sclk); #1;
        rd_en = 1'b0;
        wait_end("t3_end1_seen", 0, 100);
        chk("t3_ask_again", int'(ask), 1);
        chk("t3_pre_n",    pre_c.size(), 1);
        chk("t3_rd2pre",   qat(pre_c, 0) - qat(rd_c, 0), 4);
        chk("t3_v_first",  v_c.size(), 4);
        repeat (10) tick();
        chk("t3_hold_act", act_c.size(), 1);
        @(posedge sclk); #1;
        rd_en = 1'b1;
        wait_end("t3_end2_seen", 1, 100);
        repeat (4) tick();
        chk("t3_act_n",    act_c.size(), 2);
        chk("t3_act_row",  qat(act_a, 1), 9);
        chk("t3_rd_col",   qat(rd_a, 1), 4);
        chk("t3_v_n",      v_c.size(), 8);
        chk_stream("t3_data", 9);
        chk("t3_ask_rise", ask_rise, 2);

        // Row end: 129 bursts from row 7 cross into row 8.
        clear_logs();
        trigger(7, 129);
        wait_end("t4_end_seen", 0, 1000);
        repeat (4) tick();
        chk("t4_rd_n",     rd_c.size(), 129);
        chk("t4_rd504",    qat(rd_a, 126), 504);
        chk("t4_rd508",    qat(rd_a, 127), 508);
        chk("t4_rd_wrap",  qat(rd_a, 128), 0);
        chk("t4_act_n",    act_c.size(), 2);
        chk("t4_act_row",  qat(act_a, 1), 8);
        chk("t4_pre_n",    pre_c.size(), 2);
        chk("t4_rd2pre",   qat(pre_c, 0) - qat(rd_c, 127), 4);
        chk("t4_trp",      qat(act_c, 1) - qat(pre_c, 0), TRP);
        chk("t4_trcd",     qat(rd_c, 128) - qat(act_c, 1), TRCD);
        chk("t4_v_n",      v_c.size(), 516);
        chk_stream("t4_data", 7);
        chk("t4_end_n",    end_c.size(), 1);
        chk("t4_ask_rise", ask_rise, 1);

        // Reset while data is in flight.
        clear_logs();
        trigger(3, 3);
        for (int i = 0; i < 50 && v_c.size() < 2; i++) tick();
        @(posedge sclk); #1;
        srst = 1'b1;
        @(posedge sclk); #1;
        srst = 1'b0;
        tick();
        chk("t5_cmd",   int'(cmd), int'(NOP));
        chk("t5_ask",   int'(ask), 0);
        chk("t5_end",   int'(endp), 0);
        chk("t5_valid", int'(rvalid), 0);
        chk("t5_data",  int'(rdata), 0);
        repeat (10) tick();
        chk("t5_no_pre", pre_c.size(), 0);
        chk("t5_rd_n",   rd_c.size(), 2);
        clear_logs();
        trigger(3, 1);
        wait_end("t5_end_seen", 0, 100);
        repeat (4) tick();
        chk("t5_rerun_v", v_c.size(), 4);
        chk_stream("t5_rerun_data", 3);

        // Zero-length trigger does nothing on either instance.
        clear_logs();
        trigger(1, 0);
        repeat (10) tick();
        chk("t6_cmds",  cmd_n, 0);
        chk("t6_ask",   ask_rise, 0);
        chk("t6_cmds2", cmd2_n, 0);
        chk("t6_ask2",  ask2_n, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
